// File: rtl/fetch_redirect_ctrl_pkg.sv
// fetch_redirect_ctrl_pkg: shared fetch-state encoding and fetch constants.
package fetch_redirect_ctrl_pkg;
  typedef enum logic [1:0] {BOOT, RUN, WAIT_REDIR} fetch_state_t;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// sat_counter: saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (inc && !(&count)) count <= count + W'(1);
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: PC register, fetch handshake and branch-redirect flush control.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_src,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             stall,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  output logic [XLEN-1:0]  pc_if,
  output logic             if_valid,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             misaligned,
  output logic [CNT_W-1:0] redirect_count
);
  fetch_state_t    state;
  logic [XLEN-1:0] pc, pending, target;
  logic            accept, waiting;
  assign target      = {branch_target[XLEN-1:2], 2'b00};
  assign waiting     = state == WAIT_REDIR;
  assign imem_req    = state != BOOT;
  assign accept      = imem_req & pc_src;
  assign imem_addr   = pc;
  assign pc_if       = pc;
  assign if_valid    = state == RUN & ~pc_src & ~stall & imem_ready;
  assign flush_if_id = accept | waiting;
  assign flush_id_ex = accept;
  // pc only moves on a completed fetch, keeping imem_addr stable across wait states
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= BOOT;
      pc         <= RESET_PC;
      pending    <= '0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= accept & |branch_target[1:0];
      if (state == BOOT) state <= RUN;
      else if (state == RUN) begin
        if (pc_src & imem_ready) pc <= target;
        else if (pc_src) begin
          pending <= target;
          state   <= WAIT_REDIR;
        end else if (~stall & imem_ready) pc <= pc + XLEN'(INSTR_BYTES);
      end else begin
        if (pc_src) pending <= target;
        if (imem_ready) begin
          pc    <= pc_src ? target : pending;
          state <= RUN;
        end
      end
    end
  sat_counter #(.W(CNT_W)) u_cnt (.clk(clk), .rst_n(rst_n), .inc(accept), .count(redirect_count));
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: table vectors, directed corner cases and random traffic vs. a behavioural model.
module tb_fetch_redirect_ctrl;
  logic        clk = 0, rst_n = 0, pc_src = 0, stall = 0, imem_ready = 0;
  logic [31:0] branch_target = 0;
  logic        imem_req, if_valid, flush_if_id, flush_id_ex, misaligned;
  logic [31:0] imem_addr, pc_if;
  logic [15:0] redirect_count;
  logic        s_req, s_ifv, s_fif, s_fex, s_mis;
  logic [31:0] s_addr, s_pcif;
  logic [1:0]  s_cnt;
  int checks = 0, errors = 0;

  fetch_redirect_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .branch_target(branch_target), .stall(stall),
    .imem_ready(imem_ready), .imem_req(imem_req), .imem_addr(imem_addr), .pc_if(pc_if),
    .if_valid(if_valid), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .misaligned(misaligned), .redirect_count(redirect_count));

  fetch_redirect_ctrl #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .branch_target(branch_target), .stall(stall),
    .imem_ready(imem_ready), .imem_req(s_req), .imem_addr(s_addr), .pc_if(s_pcif),
    .if_valid(s_ifv), .flush_if_id(s_fif), .flush_id_ex(s_fex),
    .misaligned(s_mis), .redirect_count(s_cnt));

  always #5 clk = ~clk;

  // model: booting / waiting-for-redirect flags, current pc, queued target, counts
  bit          m_boot, m_wait, m_mis;
  logic [31:0] m_pc, m_pend;
  int          m_cnt, m_cnt2;

  typedef struct {
    logic ps; logic [31:0] tgt; logic st; logic rdy;
    logic [31:0] addr; logic req, ifv, fif, fex;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_wait = 0; m_mis = 0; m_pc = 0; m_pend = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic tick_a(logic ps, logic [31:0] tgt, logic st, logic rdy);
    pc_src = ps; branch_target = tgt; stall = st; imem_ready = rdy;
    @(negedge clk);
    chk("imem_req", imem_req, !m_boot);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc_if", pc_if, m_pc);
    chk("if_valid", if_valid, !m_boot && !m_wait && !ps && !st && rdy);
    chk("flush_if_id", flush_if_id, !m_boot && (m_wait || ps));
    chk("flush_id_ex", flush_id_ex, !m_boot && ps);
    chk("misaligned", misaligned, m_mis);
    chk("redirect_count", redirect_count, m_cnt);
    chk("small_count", s_cnt, m_cnt2);
  endtask

  task automatic tick_b();
    logic [31:0] al;
    bit acc;
    @(posedge clk);
    al = branch_target & ~32'h3;
    acc = !m_boot && pc_src;
    if (m_boot) m_boot = 0;
    else if (m_wait) begin
      if (pc_src) m_pend = al;
      if (imem_ready) begin m_pc = m_pend; m_wait = 0; end
    end else if (pc_src) begin
      if (imem_ready) m_pc = al;
      else begin m_pend = al; m_wait = 1; end
    end else if (!stall && imem_ready) m_pc = m_pc + 4;
    m_mis = acc && branch_target[1:0] != 0;
    if (acc && m_cnt < 65535) m_cnt++;
    if (acc && m_cnt2 < 3) m_cnt2++;
    #1;
  endtask

  task automatic cycle(logic ps, logic [31:0] tgt, logic st, logic rdy);
    tick_a(ps, tgt, st, rdy);
    tick_b();
  endtask

  task automatic do_reset();
    rst_n = 0; pc_src = 0; stall = 0; imem_ready = 0; branch_target = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  initial begin
    tbl[0] = '{0, 0,     0, 1, 32'h00,  0, 0, 0, 0};
    tbl[1] = '{0, 0,     0, 1, 32'h00,  1, 1, 0, 0};
    tbl[2] = '{0, 0,     0, 1, 32'h04,  1, 1, 0, 0};
    tbl[3] = '{0, 0,     0, 1, 32'h08,  1, 1, 0, 0};
    tbl[4] = '{0, 0,     0, 1, 32'h0C,  1, 1, 0, 0};
    tbl[5] = '{1, 32'h100, 0, 1, 32'h10, 1, 0, 1, 1};
    tbl[6] = '{0, 0,     0, 1, 32'h100, 1, 1, 0, 0};
    tbl[7] = '{0, 0,     1, 1, 32'h104, 1, 0, 0, 0};
    tbl[8] = '{0, 0,     0, 0, 32'h104, 1, 0, 0, 0};
    #1;
    chk("reset_req", imem_req, 0);
    chk("reset_addr", imem_addr, 0);
    chk("reset_count", redirect_count, 0);
    do_reset();
    foreach (tbl[i]) begin
      tick_a(tbl[i].ps, tbl[i].tgt, tbl[i].st, tbl[i].rdy);
      chk("tbl_addr", imem_addr, tbl[i].addr);
      chk("tbl_req", imem_req, tbl[i].req);
      chk("tbl_ifv", if_valid, tbl[i].ifv);
      chk("tbl_fif", flush_if_id, tbl[i].fif);
      chk("tbl_fex", flush_id_ex, tbl[i].fex);
      tick_b();
    end
    chk("tbl_count", redirect_count, 1);
    // redirect while the fetch is outstanding for 3 cycles
    cycle(1, 32'h20, 0, 1);
    cycle(1, 32'h200, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick_a(0, 0, 0, i == 2);
      chk("wait_addr", imem_addr, 32'h20);
      chk("wait_fif", flush_if_id, 1);
      chk("wait_fex", flush_id_ex, 0);
      chk("wait_ifv", if_valid, 0);
      tick_b();
    end
    tick_a(0, 0, 0, 1);
    chk("wait_target", imem_addr, 32'h200);
    tick_b();
    // stall holds pc; redirect beats stall
    cycle(1, 32'h8, 0, 1);
    for (int i = 0; i < 2; i++) begin
      tick_a(0, 0, 1, 1);
      chk("stall_addr", imem_addr, 32'h8);
      chk("stall_ifv", if_valid, 0);
      tick_b();
    end
    cycle(1, 32'h40, 1, 1);
    tick_a(0, 0, 0, 1);
    chk("stall_redir", imem_addr, 32'h40);
    tick_b();
    // misaligned target
    cycle(1, 32'h103, 0, 1);
    tick_a(0, 0, 0, 1);
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_pulse", misaligned, 1);
    tick_b();
    tick_a(0, 0, 0, 1);
    chk("mis_clear", misaligned, 0);
    tick_b();
    chk("small_sat", s_cnt, 3);
    // async reset while a redirect to 0x300 is pending
    cycle(1, 32'h40, 0, 1);
    cycle(1, 32'h300, 0, 0);
    pc_src = 0; imem_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_addr", imem_addr, 0);
    chk("arst_req", imem_req, 0);
    chk("arst_fif", flush_if_id, 0);
    chk("arst_fex", flush_id_ex, 0);
    chk("arst_count", redirect_count, 0);
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      tick_a(0, 0, 0, 1);
      chk("no_stale_target", imem_addr == 32'h300, 0);
      tick_b();
    end
    // random traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 6) == 0, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
